mdu_issue_ctrl: RTL and testbench

//   Pipeline-side controller for the multiply/divide unit. Sits in the E stage.
//   - Decodes mult/multu/div/divu/madd/mthi/mtlo/mfhi/mflo.
//   - Drives the MDU start/op/write/madd pins and counts the operation latency.
//   - Stalls the D stage and returns HI/LO for mf*.
//   - On interrupt, restores the pre-operation HI/LO of an aborted operation.

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_decode.sv | 55 +++++
 rtl/mdu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the MDU issue controller.
//   - opcode/funct codes of the MDU-class instructions
//   - MDU_OP_* operation codes driven onto mdu_op
//   - controller state codes and the instruction class encoding
package mdu_pkg;

    localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MADD  = 6'b000000;

    localparam logic [1:0] MDU_OP_MULTU = 2'b00;
    localparam logic [1:0] MDU_OP_MULT  = 2'b01;
    localparam logic [1:0] MDU_OP_DIVU  = 2'b10;
    localparam logic [1:0] MDU_OP_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL_BUSY = 2'd1;
    localparam logic [1:0] ST_DIV_BUSY = 2'd2;

    typedef enum logic [2:0] {
        MD_NONE,
        MD_MUL,
        MD_DIV,
        MD_MADD,
        MD_MT,
        MD_MF
    } md_class_e;

endpackage

// File: rtl/mdu_decode.sv
// mdu_decode: combinational decode of the E-stage instruction into MDU classes.
// Ports:
//   opcode, funct  in   instruction fields
//   is_mul         out  mult/multu
//   is_div         out  div/divu
//   is_madd        out  madd
//   is_mt          out  mthi/mtlo
//   is_mf          out  mfhi/mflo
//   op             out  MDU_OP_* code (madd uses the signed multiply code)
//   hilo           out  0 = HI, 1 = LO for mt*/mf*
module mdu_decode
    import mdu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       is_mul,
    output logic       is_div,
    output logic       is_madd,
    output logic       is_mt,
    output logic       is_mf,
    output logic [1:0] op,
    output logic       hilo
);

    md_class_e cls;

    always_comb begin
        cls  = MD_NONE;
        op   = MDU_OP_MULTU;
        hilo = 1'b0;
        if (opcode == OPC_SPECIAL) begin
            case (funct)
                FN_MULT:  begin cls = MD_MUL; op = MDU_OP_MULT;  end
                FN_MULTU: begin cls = MD_MUL; op = MDU_OP_MULTU; end
                FN_DIV:   begin cls = MD_DIV; op = MDU_OP_DIV;   end
                FN_DIVU:  begin cls = MD_DIV; op = MDU_OP_DIVU;  end
                FN_MFHI:  begin cls = MD_MF;  hilo = 1'b0;       end
                FN_MFLO:  begin cls = MD_MF;  hilo = 1'b1;       end
                FN_MTHI:  begin cls = MD_MT;  hilo = 1'b0;       end
                FN_MTLO:  begin cls = MD_MT;  hilo = 1'b1;       end
                default:  cls = MD_NONE;
            endcase
        end else if ((opcode == OPC_SPECIAL2) && (funct == FN_MADD)) begin
            cls = MD_MADD;
            op  = MDU_OP_MULT;
        end
    end

    assign is_mul  = (cls == MD_MUL);
    assign is_div  = (cls == MD_DIV);
    assign is_madd = (cls == MD_MADD);
    assign is_mt   = (cls == MD_MT);
    assign is_mf   = (cls == MD_MF);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage controller for the multiply/divide unit.
// Issues mult/multu/div/divu/madd to the MDU, times the operation latency,
// stalls the D stage while the MDU is busy, serves mthi/mtlo/mfhi/mflo, and
// on an interrupt hands the MDU the HI/LO it held before the aborted operation.
//
// Optional feature macro: DIV0_TRAP_EN
//   defined   : div/divu with rt_e==0 is not started; div0_trap pulses instead.
//   undefined : such a divide is started normally and occupies DIV_LAT cycles.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   md_d                     D-stage instruction is MDU-class
//   instr_valid_e, flush_e   E-stage valid / kill
//   opcode_e, funct_e        E-stage instruction fields
//   rs_e, rt_e               E-stage operands
//   int_req                  interrupt/exception taken this cycle
//   mdu_hi, mdu_lo           current HI/LO from the MDU
//   mdu_start, mdu_op        start pulse and operation code
//   mdu_madd                 madd issue pulse
//   mdu_we, mdu_hilo         mthi/mtlo write strobe and target (0 HI, 1 LO)
//   mdu_d1, mdu_d2           operands to the MDU
//   mdu_int_req              restore request to the MDU
//   hi_restore, lo_restore   shadowed HI/LO
//   stall_d                  freeze F/D, bubble E
//   mf_data_e                mfhi/mflo read data
//   div0_trap                (DIV0_TRAP_EN only) divide-by-zero pulse
//
// state        | meaning
// ST_IDLE      | no operation in flight, new MDU instructions accepted
// ST_MUL_BUSY  | mult/multu/madd in flight, cnt = cycles left minus one
// ST_DIV_BUSY  | div/divu in flight, cnt = cycles left minus one
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_d,
    input  logic        instr_valid_e,
    input  logic        flush_e,
    input  logic [5:0]  opcode_e,
    input  logic [5:0]  funct_e,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        int_req,
    input  logic [31:0] mdu_hi,
    input  logic [31:0] mdu_lo,
    output logic        mdu_start,
    output logic [1:0]  mdu_op,
    output logic        mdu_madd,
    output logic        mdu_we,
    output logic        mdu_hilo,
    output logic [31:0] mdu_d1,
    output logic [31:0] mdu_d2,
    output logic        mdu_int_req,
    output logic [31:0] hi_restore,
    output logic [31:0] lo_restore,
`ifdef DIV0_TRAP_EN
    output logic        div0_trap,
`endif
    output logic        stall_d,
    output logic [31:0] mf_data_e
);

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_LAT - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] shadow_hi;
    logic [31:0] shadow_lo;

    logic        is_mul, is_div, is_madd, is_mt, is_mf;
    logic [1:0]  dec_op;
    logic        dec_hilo;

    logic        idle;
    logic        go;
    logic        issue_mul;
    logic        issue_div;
    logic        issue;

    mdu_decode u_decode (
        .opcode  (opcode_e),
        .funct   (funct_e),
        .is_mul  (is_mul),
        .is_div  (is_div),
        .is_madd (is_madd),
        .is_mt   (is_mt),
        .is_mf   (is_mf),
        .op      (dec_op),
        .hilo    (dec_hilo)
    );

    assign idle = (state == ST_IDLE);
    // rst is folded in so every combinational output reads 0 while reset is held.
    assign go   = ~rst & instr_valid_e & ~flush_e & ~int_req & idle;

    assign issue_mul = go & (is_mul | is_madd);
`ifdef DIV0_TRAP_EN
    assign issue_div = go & is_div & (rt_e != 32'd0);
    assign div0_trap = go & is_div & (rt_e == 32'd0);
`else
    // A zero divisor still runs the full divide so the timing never depends on data.
    assign issue_div = go & is_div;
`endif
    assign issue = issue_mul | issue_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            shadow_hi <= 32'd0;
            shadow_lo <= 32'd0;
        end else if (!idle) begin
            if (int_req) begin
                state <= ST_IDLE;
                cnt   <= 4'd0;
            end else if (cnt == 4'd0) begin
                // The result is now architectural: it becomes the new restore point.
                state     <= ST_IDLE;
                shadow_hi <= mdu_hi;
                shadow_lo <= mdu_lo;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (issue) begin
            state     <= issue_div ? ST_DIV_BUSY : ST_MUL_BUSY;
            cnt       <= issue_div ? DIV_CNT_INIT : MUL_CNT_INIT;
            shadow_hi <= mdu_hi;
            shadow_lo <= mdu_lo;
        end
    end

    assign mdu_start   = issue & ~is_madd;
    assign mdu_madd    = issue_mul & is_madd;
    assign mdu_op      = issue ? dec_op : 2'b00;
    assign mdu_we      = go & is_mt;
    assign mdu_hilo    = go & is_mt & dec_hilo;
    assign mdu_d1      = rst ? 32'd0 : rs_e;
    assign mdu_d2      = rst ? 32'd0 : rt_e;
    assign mdu_int_req = ~rst & int_req & ~idle;
    assign hi_restore  = shadow_hi;
    assign lo_restore  = shadow_lo;
    assign stall_d     = ~rst & md_d & (~idle | issue);

    always_comb begin
        mf_data_e = 32'd0;
        if (!rst && is_mf) begin
            mf_data_e = dec_hilo ? mdu_lo : mdu_hi;
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
module tb_mdu_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    typedef enum int {
        K_MULT, K_MULTU, K_DIV, K_DIVU, K_MADD,
        K_MFHI, K_MTHI, K_MFLO, K_MTLO,
        K_ADD, K_LW, K_SP2MUL, K_NUM
    } kind_e;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_d;
    logic        instr_valid_e;
    logic        flush_e;
    logic [5:0]  opcode_e;
    logic [5:0]  funct_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        int_req;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;
    logic        mdu_start;
    logic [1:0]  mdu_op;
    logic        mdu_madd;
    logic        mdu_we;
    logic        mdu_hilo;
    logic [31:0] mdu_d1;
    logic [31:0] mdu_d2;
    logic        mdu_int_req;
    logic [31:0] hi_restore;
    logic [31:0] lo_restore;
    logic        stall_d;
    logic [31:0] mf_data_e;
`ifdef DIV0_TRAP_EN
    logic        div0_trap;
`endif

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .md_d          (md_d),
        .instr_valid_e (instr_valid_e),
        .flush_e       (flush_e),
        .opcode_e      (opcode_e),
        .funct_e       (funct_e),
        .rs_e          (rs_e),
        .rt_e          (rt_e),
        .int_req       (int_req),
        .mdu_hi        (mdu_hi),
        .mdu_lo        (mdu_lo),
        .mdu_start     (mdu_start),
        .mdu_op        (mdu_op),
        .mdu_madd      (mdu_madd),
        .mdu_we        (mdu_we),
        .mdu_hilo      (mdu_hilo),
        .mdu_d1        (mdu_d1),
        .mdu_d2        (mdu_d2),
        .mdu_int_req   (mdu_int_req),
        .hi_restore    (hi_restore),
        .lo_restore    (lo_restore),
`ifdef DIV0_TRAP_EN
        .div0_trap     (div0_trap),
`endif
        .stall_d       (stall_d),
        .mf_data_e     (mf_data_e)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: remaining busy cycles plus the restore point.
    kind_e       kind;
    int          busy_left;
    logic [31:0] m_shi;
    logic [31:0] m_slo;
    bit          m_idle;
    bit          m_iss;
    bit          m_isdiv;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic set_kind(input kind_e k);
        kind = k;
        case (k)
            K_MULT:   begin opcode_e = 6'b000000; funct_e = 6'b011000; end
            K_MULTU:  begin opcode_e = 6'b000000; funct_e = 6'b011001; end
            K_DIV:    begin opcode_e = 6'b000000; funct_e = 6'b011010; end
            K_DIVU:   begin opcode_e = 6'b000000; funct_e = 6'b011011; end
            K_MADD:   begin opcode_e = 6'b011100; funct_e = 6'b000000; end
            K_MFHI:   begin opcode_e = 6'b000000; funct_e = 6'b010000; end
            K_MTHI:   begin opcode_e = 6'b000000; funct_e = 6'b010001; end
            K_MFLO:   begin opcode_e = 6'b000000; funct_e = 6'b010010; end
            K_MTLO:   begin opcode_e = 6'b000000; funct_e = 6'b010011; end
            K_ADD:    begin opcode_e = 6'b000000; funct_e = 6'b100000; end
            K_LW:     begin opcode_e = 6'b100011; funct_e = 6'b011000; end
            default:  begin opcode_e = 6'b011100; funct_e = 6'b000010; end
        endcase
    endtask

    task automatic drive(input kind_e k, input logic v, input logic [31:0] rs, input logic [31:0] rt,
                         input logic md, input logic irq = 1'b0, input logic fl = 1'b0);
        set_kind(k);
        instr_valid_e = v;
        rs_e          = rs;
        rt_e          = rt;
        md_d          = md;
        int_req       = irq;
        flush_e       = fl;
    endtask

    // Checks every output against the model, mid-cycle.
    task automatic settle();
        bit mul, div, madd, mt, go, start_e;
        logic [1:0]  eop;
        logic [31:0] emf;
`ifdef DIV0_TRAP_EN
        bit d0;
`endif
        #2;
        mul  = (kind == K_MULT) || (kind == K_MULTU);
        div  = (kind == K_DIV) || (kind == K_DIVU);
        madd = (kind == K_MADD);
        mt   = (kind == K_MTHI) || (kind == K_MTLO);
        m_idle  = (busy_left == 0);
        m_isdiv = div;
        go = instr_valid_e && !flush_e && !int_req && m_idle;
`ifdef DIV0_TRAP_EN
        d0    = div && (rt_e == 32'd0);
        m_iss = go && (mul || madd || (div && !d0));
        chk1("div0_trap", div0_trap, go && d0);
`else
        m_iss = go && (mul || madd || div);
`endif
        start_e = m_iss && !madd;
        case (kind)
            K_MULTU: eop = 2'b00;
            K_MULT:  eop = 2'b01;
            K_DIVU:  eop = 2'b10;
            default: eop = 2'b11;
        endcase
        if (kind == K_MFHI)      emf = mdu_hi;
        else if (kind == K_MFLO) emf = mdu_lo;
        else                     emf = 32'd0;

        chk1("start", mdu_start, start_e);
        chk1("madd", mdu_madd, m_iss && madd);
        if (start_e) chk32("op", {30'd0, mdu_op}, {30'd0, eop});
        chk1("we", mdu_we, go && mt);
        if (go && mt) chk1("hilo", mdu_hilo, kind == K_MTLO);
        chk1("stall_d", stall_d, md_d && (!m_idle || m_iss));
        chk1("mdu_int_req", mdu_int_req, int_req && !m_idle);
        if (int_req && !m_idle) begin
            chk32("hi_restore", hi_restore, m_shi);
            chk32("lo_restore", lo_restore, m_slo);
        end
        chk32("d1", mdu_d1, rs_e);
        chk32("d2", mdu_d2, rt_e);
        chk32("mf_data", mf_data_e, emf);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!m_idle) begin
            if (int_req) begin
                busy_left = 0;
            end else if (busy_left == 1) begin
                busy_left = 0;
                m_shi = mdu_hi;
                m_slo = mdu_lo;
            end else begin
                busy_left--;
            end
        end else if (m_iss) begin
            busy_left = m_isdiv ? DIV_LAT : MUL_LAT;
            m_shi = mdu_hi;
            m_slo = mdu_lo;
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_start"}, mdu_start, 1'b0);
        chk32({tag, "_op"}, {30'd0, mdu_op}, 32'd0);
        chk1({tag, "_madd"}, mdu_madd, 1'b0);
        chk1({tag, "_we"}, mdu_we, 1'b0);
        chk1({tag, "_hilo"}, mdu_hilo, 1'b0);
        chk32({tag, "_d1"}, mdu_d1, 32'd0);
        chk32({tag, "_d2"}, mdu_d2, 32'd0);
        chk1({tag, "_int"}, mdu_int_req, 1'b0);
        chk32({tag, "_hir"}, hi_restore, 32'd0);
        chk32({tag, "_lor"}, lo_restore, 32'd0);
        chk1({tag, "_stall"}, stall_d, 1'b0);
        chk32({tag, "_mf"}, mf_data_e, 32'd0);
`ifdef DIV0_TRAP_EN
        chk1({tag, "_trap"}, div0_trap, 1'b0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        mdu_hi = 32'hA5A5_0001;
        mdu_lo = 32'h5A5A_0002;
        busy_left = 0;
        m_shi = 32'd0;
        m_slo = 32'd0;
        drive(K_MULT, 1'b1, 32'h1234, 32'h5678, 1'b1);
        #3;
        chk_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: mult -1 * 2, stall for issue + MUL_LAT cycles, result shadowed at completion
        mdu_hi = 32'd0; mdu_lo = 32'd0;
        drive(K_MULT, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        settle();
        chk1("t1_start", mdu_start, 1'b1);
        chk32("t1_op", {30'd0, mdu_op}, 32'd1);
        chk1("t1_stall_issue", stall_d, 1'b1);
        tick();
        mdu_hi = 32'hFFFF_FFFF; mdu_lo = 32'hFFFF_FFFE;
        for (int i = 0; i < MUL_LAT; i++) begin
            drive(K_ADD, 1'b1, 32'd0, 32'd0, 1'b1);
            settle();
            chk1("t1_stall_busy", stall_d, 1'b1);
            tick();
        end
        mdu_hi = 32'h0BAD_0BAD; mdu_lo = 32'h0DEF_0DEF;
        settle();
        chk1("t1_idle", stall_d, 1'b0);
        chk32("t1_shadow_hi", hi_restore, 32'hFFFF_FFFF);
        chk32("t1_shadow_lo", lo_restore, 32'hFFFF_FFFE);
        tick();

        // 2: divu 7/2, then mfhi/mflo
        drive(K_DIVU, 1'b1, 32'd7, 32'd2, 1'b0);
        settle();
        chk32("t2_op", {30'd0, mdu_op}, 32'd2);
        tick();
        mdu_hi = 32'd1; mdu_lo = 32'd3;
        for (int i = 0; i < DIV_LAT; i++) begin
            drive(K_ADD, 1'b1, 32'd0, 32'd0, 1'b1);
            settle();
            chk1("t2_stall_busy", stall_d, 1'b1);
            tick();
        end
        drive(K_MFHI, 1'b1, 32'd0, 32'd0, 1'b1);
        settle();
        chk1("t2_idle", stall_d, 1'b0);
        chk32("t2_mfhi", mf_data_e, 32'd1);
        tick();
        drive(K_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
        settle();
        chk32("t2_mflo", mf_data_e, 32'd3);
        tick();

        // 3: interrupt during mult restores pre-operation HI/LO
        mdu_hi = 32'h11; mdu_lo = 32'h22;
        drive(K_MULT, 1'b1, 32'd3, 32'd4, 1'b0);
        step();
        mdu_hi = 32'h0; mdu_lo = 32'hC;
        drive(K_ADD, 1'b1, 32'd0, 32'd0, 1'b1);
        step();
        drive(K_ADD, 1'b1, 32'd0, 32'd0, 1'b1, 1'b1);
        settle();
        chk1("t3_int", mdu_int_req, 1'b1);
        chk32("t3_hi_restore", hi_restore, 32'h11);
        chk32("t3_lo_restore", lo_restore, 32'h22);
        tick();
        drive(K_ADD, 1'b1, 32'd0, 32'd0, 1'b1);
        settle();
        chk1("t3_idle", stall_d, 1'b0);
        tick();

        // 4: int_req beats an issue; flush kills an issue; int_req while idle
        drive(K_DIV, 1'b1, 32'd9, 32'd3, 1'b1, 1'b1);
        settle();
        chk1("t4_int_start", mdu_start, 1'b0);
        chk1("t4_int_stall", stall_d, 1'b0);
        chk1("t4_idle_int", mdu_int_req, 1'b0);
        tick();
        drive(K_MULT, 1'b1, 32'd5, 32'd6, 1'b1, 1'b0, 1'b1);
        settle();
        chk1("t4_flush_start", mdu_start, 1'b0);
        chk1("t4_flush_stall", stall_d, 1'b0);
        tick();
        drive(K_ADD, 1'b1, 32'd0, 32'd0, 1'b1);
        settle();
        chk1("t4_still_idle", stall_d, 1'b0);
        tick();

        // 5: divide by zero
        drive(K_DIV, 1'b1, 32'd8, 32'd0, 1'b1);
        settle();
`ifdef DIV0_TRAP_EN
        chk1("t5_trap", div0_trap, 1'b1);
        chk1("t5_start", mdu_start, 1'b0);
        chk1("t5_stall", stall_d, 1'b0);
        tick();
`else
        chk1("t5_start", mdu_start, 1'b1);
        tick();
        for (int i = 0; i < DIV_LAT; i++) begin
            drive(K_ADD, 1'b1, 32'd0, 32'd0, 1'b1);
            settle();
            chk1("t5_stall_busy", stall_d, 1'b1);
            tick();
        end
`endif
        drive(K_ADD, 1'b1, 32'd0, 32'd0, 1'b1);
        settle();
        chk1("t5_idle", stall_d, 1'b0);
        tick();

        // 6: asynchronous reset mid-divide
        drive(K_DIVU, 1'b1, 32'd100, 32'd7, 1'b0);
        step();
        drive(K_ADD, 1'b1, 32'd0, 32'd0, 1'b1);
        step();
        drive(K_MTHI, 1'b1, 32'hCAFE, 32'hBEEF, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mt");
        set_kind(K_MFHI);
        mdu_hi = 32'h7777;
        #1;
        chk_reset_outputs("rst_mf");
        #1;
        rst = 1'b0;
        busy_left = 0;
        m_shi = 32'd0;
        m_slo = 32'd0;
        @(posedge clk);
        #1;
        drive(K_MTHI, 1'b1, 32'hCAFE, 32'd0, 1'b1);
        settle();
        chk1("t6_we", mdu_we, 1'b1);
        chk1("t6_hilo", mdu_hilo, 1'b0);
        chk1("t6_stall", stall_d, 1'b0);
        chk32("t6_hi_restore", hi_restore, 32'd0);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            drive(kind_e'($urandom_range(0, K_NUM - 1)),
                  ($urandom_range(0, 99) < 85),
                  $urandom,
                  ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 6),
                  ($urandom_range(0, 99) < 10));
            mdu_hi = $urandom;
            mdu_lo = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
